// File: rtl/tds_link_checker.sv
//==============================================================================
// Module  : tds_link_checker
// Brief   : Multi-channel recovered-word checker with per-channel lock FSM,
//           saturating error counters and forwarding of words received locked.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tds_link_checker #(
  parameter int                NCH      = 2,
  parameter int                DATA_W   = 30,
  parameter int                SYNC_LEN = 512,
  parameter int                LOSS_LEN = 4,
  parameter int                SYN_W    = 10,
  parameter int                ERR_W    = 5,
  parameter logic [DATA_W-1:0] PATTERN  = DATA_W'(30'h2AAAAAAA)
) (
  input  logic                  clk160,
  input  logic                  reset_160M_n,
  input  logic                  mode,
  input  logic                  clear_cnt,
  input  logic [NCH*DATA_W-1:0] data_in,
  input  logic [NCH-1:0]        data_valid_in,
  output logic [NCH-1:0]        linked,
  output logic [NCH*2-1:0]      state,
  output logic [NCH*SYN_W-1:0]  syn_cnt,
  output logic [NCH*ERR_W-1:0]  err_cnt,
  output logic [NCH-1:0]        data_valid,
  output logic [NCH*DATA_W-1:0] data_out
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_SYNC    = 2'd1,
    S_LOCKED  = 2'd2,
    S_ILLEGAL = 2'd3
  } state_t;

  localparam logic [SYN_W-1:0] c_sync_len = SYN_W'(SYNC_LEN);
  localparam logic [3:0]       c_loss_len = 4'(LOSS_LEN);
  localparam logic [ERR_W-1:0] c_err_max  = '1;

  if (SYNC_LEN < 1 || SYNC_LEN >= (1 << SYN_W)) begin : g_chk_sync_len
    $fatal(1, "tds_link_checker: SYNC_LEN must be in 1..2^SYN_W-1");
  end

  if (LOSS_LEN < 1 || LOSS_LEN > 15) begin : g_chk_loss_len
    $fatal(1, "tds_link_checker: LOSS_LEN must be in 1..15");
  end

  // Shadow of mode; any change forces every channel back to HUNT.
  logic r_mode_q;
  logic w_mode_chg;

  assign w_mode_chg = (mode != r_mode_q);

  always_ff @(posedge clk160 or negedge reset_160M_n) begin
    if (!reset_160M_n) r_mode_q <= 1'b0;
    else               r_mode_q <= mode;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t            r_state;
    logic [SYN_W-1:0]  r_syn;
    logic [ERR_W-1:0]  r_err;
    logic [3:0]        r_bad;
    logic [DATA_W-1:0] r_last;
    logic [DATA_W-1:0] r_dout;
    logic              r_dv;

    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_expect;
    logic              w_vld;
    logic              w_good;
    logic [SYN_W-1:0]  w_syn_inc;
    logic [3:0]        w_bad_inc;

    assign w_word    = data_in[i*DATA_W +: DATA_W];
    assign w_vld     = data_valid_in[i];
    assign w_expect  = mode ? PATTERN : (r_last + DATA_W'(1));
    assign w_good    = (w_word == w_expect);
    assign w_syn_inc = r_syn + SYN_W'(1);
    assign w_bad_inc = r_bad + 4'd1;

    always_ff @(posedge clk160 or negedge reset_160M_n) begin
      if (!reset_160M_n) begin
        r_state <= S_HUNT;
        r_syn   <= '0;
        r_err   <= '0;
        r_bad   <= '0;
        r_last  <= '0;
        r_dout  <= '0;
        r_dv    <= 1'b0;
      end else begin
        r_dv <= 1'b0;
        if (clear_cnt) r_err <= '0;
        if (w_mode_chg) begin
          r_state <= S_HUNT;
          r_syn   <= '0;
          r_bad   <= '0;
        end else begin
          if (w_vld) r_last <= w_word;
          case (r_state)
            S_HUNT: begin
              // Counter mode seeds from any word; fixed mode waits for PATTERN.
              if (w_vld && (!mode || w_good)) begin
                r_state <= S_SYNC;
                r_syn   <= '0;
              end
            end
            S_SYNC: begin
              if (w_vld) begin
                if (w_good) begin
                  r_syn <= w_syn_inc;
                  if (w_syn_inc == c_sync_len) r_state <= S_LOCKED;
                end else begin
                  r_state <= S_HUNT;
                  r_syn   <= '0;
                end
              end
            end
            S_LOCKED: begin
              if (w_vld) begin
                r_dv   <= 1'b1;
                r_dout <= w_word;
                if (w_good) begin
                  r_bad <= '0;
                end else begin
                  // A simultaneous clear wins; that error is dropped.
                  if (!clear_cnt && r_err != c_err_max) r_err <= r_err + ERR_W'(1);
                  if (w_bad_inc == c_loss_len) begin
                    r_state <= S_HUNT;
                    r_syn   <= '0;
                    r_bad   <= '0;
                  end else begin
                    r_bad <= w_bad_inc;
                  end
                end
              end
            end
            default: begin
              r_state <= S_HUNT;
              r_syn   <= '0;
              r_bad   <= '0;
            end
          endcase
        end
      end
    end

    assign linked[i]                   = (r_state == S_LOCKED);
    assign state[i*2 +: 2]             = r_state;
    assign syn_cnt[i*SYN_W +: SYN_W]   = r_syn;
    assign err_cnt[i*ERR_W +: ERR_W]   = r_err;
    assign data_valid[i]               = r_dv;
    assign data_out[i*DATA_W +: DATA_W] = r_dout;
  end

endmodule

`default_nettype wire

// File: doc/tds_link_checker.md
Name: tds_link_checker

Overview:
- Parametrised, multi-channel successor to the single-channel strip/pad data checkers.
- Sits on the 160 MHz domain after the deserialisers.
- Checks each channel's recovered words against a selectable expected pattern (incrementing counter or fixed word), runs a per-channel lock state machine, and keeps saturating error counters.
- Forwards words received while locked, with per-channel valid.

Parameters:
NCH, 2, number of independent channels
DATA_W, 30, bits per received word
SYNC_LEN, 512, consecutive good words in SYNC required to declare lock (1..2^SYN_W-1)
LOSS_LEN, 4, consecutive bad words in LOCKED that drop lock (1..15)
SYN_W, 10, width of each syn_cnt field
ERR_W, 5, width of each err_cnt field
PATTERN, 30'h2AAAAAAA, expected word in fixed mode (low DATA_W bits used)

Ports:
clk160  in  1  system clock, all logic on rising edge
reset_160M_n  in  1  asynchronous active-low reset
mode  in  1  0 = incrementing-counter pattern, 1 = fixed PATTERN
clear_cnt  in  1  synchronous clear of all err_cnt fields
data_in  in  NCH*DATA_W  channel i word at [i*DATA_W +: DATA_W]
data_valid_in  in  NCH  per-channel word strobe
linked  out  NCH  channel in LOCKED
state  out  NCH*2  per-channel FSM state (HUNT=0, SYNC=1, LOCKED=2)
syn_cnt  out  NCH*SYN_W  per-channel good-word count in SYNC
err_cnt  out  NCH*ERR_W  per-channel saturating error count
data_valid  out  NCH  forwarded-word strobe
data_out  out  NCH*DATA_W  forwarded words

Behaviour:
- Reset (async, reset_160M_n=0): all outputs 0; all channels HUNT; internal last-word, bad-run and mode-shadow registers 0.
- Channels are fully independent; only mode and clear_cnt are shared.
- Expected word:
  - mode 0: last_word+1 mod 2^DATA_W, where last_word is the previous valid word on that channel. Wrap-around 0x3FFFFFFF -> 0 is good.
  - mode 1: PATTERN.
  - good = data_valid_in[i] and data_in==expected. bad = data_valid_in[i] and not good.
- last_word updates on every valid word in every state.
- Cycles with data_valid_in[i]=0 change nothing for channel i.
- FSM, evaluated on a valid word:
  - HUNT: mode 0 -> any word seeds last_word; go SYNC; syn_cnt=0. mode 1 -> word==PATTERN goes SYNC with syn_cnt=0; otherwise stay.
  - SYNC: good -> syn_cnt+1. When syn_cnt+1==SYNC_LEN go LOCKED; syn_cnt holds SYNC_LEN. bad -> HUNT; syn_cnt=0.
  - LOCKED: good -> bad_run=0. bad -> err_cnt+1 (saturating), bad_run+1. When bad_run+1==LOSS_LEN go HUNT; syn_cnt=0; bad_run=0.
  - Encoding 3 is illegal and recovers to HUNT next cycle.
- Outputs are registered and reflect the state after the edge. linked[i] = (state==LOCKED).
- Forwarding:
  - data_valid[i]=1 one cycle after a valid word that arrived while the channel was already LOCKED, good or bad.
  - data_out holds that word and holds its value otherwise.
  - The word completing SYNC is not forwarded.
- err_cnt:
  - Counts only bad words in LOCKED; saturates at 2^ERR_W-1.
  - Cumulative across relocks.
  - clear_cnt=1 zeroes all channels next edge and takes priority over a simultaneous increment; that error is lost.
- Mode change: a registered shadow of mode is compared each cycle. On a change, all channels go HUNT next edge with syn_cnt=0 and bad_run=0; err_cnt is kept and that cycle's words are ignored.
- Reset mid-operation: immediate return to reset values regardless of state.
- Elaboration check: SYNC_LEN must be below 2^SYN_W; violation is a fatal elaboration error.

Test Plan:
1. Bench params SYNC_LEN=4, LOSS_LEN=2, mode 0. Channel 0 sends 10,11,12,13,14 -> state 1 after word 10. linked rises 1 cycle after word 14; syn_cnt=4. First data_valid follows word 15.
2. Locked channel 0 with mode 0 sends 20,99,21 -> 99 and 21 both bad. err_cnt=2; HUNT after 21; syn_cnt=0. Channel 1 is unaffected throughout.
3. Mode 0 counter wrap, DATA_W=30: words 3FFFFFFE,3FFFFFFF,0,1,2 -> lock achieved with err_cnt=0.
4. Mode 1 with PATTERN words only -> locks after 5 valid words. Then 2A, PATTERN -> err_cnt 1, bad_run resets, stays linked. err_cnt saturates at 31 after 31+ non-consecutive errors.
5. clear_cnt asserted in the same cycle as a LOCKED error -> err_cnt=0 next cycle. Mode toggled while locked -> all linked drop next cycle; err_cnt retained.
6. reset_160M_n pulsed low for 3 ns between edges while locked -> all outputs 0 immediately. Relock requires full SYNC_LEN again.
